// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared types and constants for the memory-stage sequencer.
//   - state_t : controller states (IDLE, RD_WAIT, WR)
//   - op_t    : request kind latched at acceptance
//   - RD_LAT_MAX : largest supported RAM read latency
package mem_access_pkg;

   localparam int RD_LAT_MAX = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR      = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_FETCH = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2
   } op_t;

endpackage

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if
//   Bundles the pipeline-side request/response signals and the RAM port.
//   master : pipeline + RAM model side (drives requests and ram_q)
//   slave  : the sequencer (drives ready/stall/valids/rdata and the RAM controls)
interface mem_access_seq_if #(
   parameter int AW = 12,
   parameter int DW = 16
) ();
   logic          fetch_req;
   logic [AW-1:0] pc;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          ready;
   logic          stall;
   logic          instr_valid;
   logic          load_valid;
   logic [DW-1:0] rdata_out;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_q;

   modport master (
      output fetch_req, pc, mem_req, mem_we, mem_addr, mem_wdata, ram_q,
      input  ready, stall, instr_valid, load_valid, rdata_out,
      input  ram_addr, ram_wren, ram_wdata
   );

   modport slave (
      input  fetch_req, pc, mem_req, mem_we, mem_addr, mem_wdata, ram_q,
      output ready, stall, instr_valid, load_valid, rdata_out,
      output ram_addr, ram_wren, ram_wdata
   );
endinterface

// File: rtl/mem_store_buf.sv
// mem_store_buf
//   One-entry posted store buffer: valid/address/data plus an address
//   compare used for load/fetch forwarding.
//   Ports: clk, rst_n (async, active-low), cap (capture a store), clr
//   (entry drained), cap_addr/cap_data, cmp_addr (address to match),
//   vld/addr/data (entry contents), hit (vld and address match).
module mem_store_buf #(
   parameter int AW = 12,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cap,
   input  logic          clr,
   input  logic [AW-1:0] cap_addr,
   input  logic [DW-1:0] cap_data,
   input  logic [AW-1:0] cmp_addr,
   output logic          vld,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data,
   output logic          hit
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= 1'b0;
      end else if (cap) begin
         vld <= 1'b1;
      end else if (clr) begin
         vld <= 1'b0;
      end
   end

   // Payload only matters while vld is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (cap) begin
         addr <= cap_addr;
         data <= cap_data;
      end
   end

   assign hit = vld && (addr == cmp_addr);

endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq
//   Memory-stage sequencer: serialises instruction fetch, load and store
//   onto one single-port synchronous RAM with a read latency of RD_LAT
//   (1..RD_LAT_MAX) cycles, and returns ready/stall and valid pulses.
//   Ports: clk, rst_n (async, active-low), bus (mem_access_seq_if.slave):
//     requests fetch_req/pc, mem_req/mem_we/mem_addr/mem_wdata;
//     responses ready, stall, instr_valid, load_valid, rdata_out;
//     RAM ram_addr/ram_wren/ram_wdata (registered), ram_q.
//   Build option: define STORE_BUF_EN for a one-entry posted store buffer
//   with load/fetch forwarding; undefined, every store takes a WR cycle.
module mem_access_seq
   import mem_access_pkg::*;
#(
   parameter int AW     = 12,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input logic             clk,
   input logic             rst_n,
   mem_access_seq_if.slave bus
);

   localparam int CW = $clog2(RD_LAT + 1);
   localparam logic [CW-1:0] LAT_C = CW'(RD_LAT);
   localparam logic [CW-1:0] ONE_C = CW'(1);

   state_t        state, state_nx;
   op_t           op, op_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [AW-1:0] addr_q, addr_nx;
   logic [DW-1:0] wdata_q, wdata_nx;
   logic [DW-1:0] rdata_q, rdata_nx;
   logic          wren_q, wren_nx;
   logic          ivld_q, ivld_nx;
   logic          lvld_q, lvld_nx;
   logic          ready;

`ifdef STORE_BUF_EN
   logic          buf_cap, drain;
   logic          buf_vld, buf_hit;
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] buf_data;

   mem_store_buf #(.AW(AW), .DW(DW)) u_sbuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap      (buf_cap),
      .clr      (drain),
      .cap_addr (bus.mem_addr),
      .cap_data (bus.mem_wdata),
      .cmp_addr (addr_q),
      .vld      (buf_vld),
      .addr     (buf_addr),
      .data     (buf_data),
      .hit      (buf_hit)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op      <= OP_FETCH;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wren_q  <= 1'b0;
         ivld_q  <= 1'b0;
         lvld_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         op      <= op_nx;
         cnt     <= cnt_nx;
         addr_q  <= addr_nx;
         wdata_q <= wdata_nx;
         rdata_q <= rdata_nx;
         wren_q  <= wren_nx;
         ivld_q  <= ivld_nx;
         lvld_q  <= lvld_nx;
      end
   end

   always_comb begin
      state_nx = state;
      op_nx    = op;
      cnt_nx   = cnt;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      rdata_nx = rdata_q;
      wren_nx  = 1'b0;
      ivld_nx  = 1'b0;
      lvld_nx  = 1'b0;
      ready    = 1'b0;
`ifdef STORE_BUF_EN
      buf_cap  = 1'b0;
      drain    = 1'b0;
`endif
      case (state)
         IDLE: begin
            ready = 1'b1;
            // mem_req wins over fetch_req; the loser simply stays pending.
            if (bus.mem_req && bus.mem_we) begin
`ifdef STORE_BUF_EN
               if (!buf_vld) begin
                  buf_cap = 1'b1;
               end else begin
                  // Full buffer: refuse the store and drain to make room.
                  ready = 1'b0;
                  drain = 1'b1;
               end
`else
               state_nx = WR;
               op_nx    = OP_STORE;
               wren_nx  = 1'b1;
               addr_nx  = bus.mem_addr;
               wdata_nx = bus.mem_wdata;
`endif
            end else if (bus.mem_req) begin
               state_nx = RD_WAIT;
               op_nx    = OP_LOAD;
               cnt_nx   = ONE_C;
               addr_nx  = bus.mem_addr;
            end else if (bus.fetch_req) begin
               state_nx = RD_WAIT;
               op_nx    = OP_FETCH;
               cnt_nx   = ONE_C;
               addr_nx  = bus.pc;
`ifdef STORE_BUF_EN
            end else if (buf_vld) begin
               drain = 1'b1;
`endif
            end else begin
               addr_nx = bus.pc;
            end
         end
         RD_WAIT: begin
            // ram_addr is held here; ram_q is taken in the last wait cycle.
            if (cnt == LAT_C) begin
               state_nx = IDLE;
               cnt_nx   = '0;
`ifdef STORE_BUF_EN
               rdata_nx = buf_hit ? buf_data : bus.ram_q;
`else
               rdata_nx = bus.ram_q;
`endif
               if (op == OP_LOAD) lvld_nx = 1'b1;
               else               ivld_nx = 1'b1;
            end else begin
               cnt_nx = cnt + ONE_C;
            end
         end
         WR: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
`ifdef STORE_BUF_EN
      if (drain) begin
         state_nx = WR;
         op_nx    = OP_STORE;
         wren_nx  = 1'b1;
         addr_nx  = buf_addr;
         wdata_nx = buf_data;
      end
`endif
   end

   assign bus.ready       = ready;
   assign bus.stall       = ~ready & (bus.fetch_req | bus.mem_req);
   assign bus.instr_valid = ivld_q;
   assign bus.load_valid  = lvld_q;
   assign bus.rdata_out   = rdata_q;
   assign bus.ram_addr    = addr_q;
   assign bus.ram_wren    = wren_q;
   assign bus.ram_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq
//   Bench for mem_access_seq: one instance with RD_LAT=1 (cycle table,
//   random stream against a reference memory) and one with RD_LAT=3
//   (priority and mid-transfer reset sequences). Each instance has its
//   own RAM model whose read data is combinational on the held ram_addr.
module tb_mem_access_seq;

   logic clk     = 1'b0;
   logic rst_n   = 1'b0;
   logic clr_mem = 1'b1;
   int   total   = 0;
   int   bad     = 0;

   always #5 clk = ~clk;

   mem_access_seq_if #(.AW(12), .DW(16)) b1 ();
   mem_access_seq_if #(.AW(12), .DW(16)) b3 ();

   mem_access_seq #(.AW(12), .DW(16), .RD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1)
   );
   mem_access_seq #(.AW(12), .DW(16), .RD_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(b3)
   );

   function automatic logic [15:0] ram_init(input logic [11:0] a);
      case (a)
         12'h010: ram_init = 16'hA5A5;
         12'h030: ram_init = 16'h5A5A;
         12'h040: ram_init = 16'h0000;
         12'h050: ram_init = 16'h2222;
         12'h200: ram_init = 16'h1111;
         default: ram_init = {4'hC, a} ^ 16'h3C3C;
      endcase
   endfunction

   // RAM models: unwritten words read as ram_init(addr).
   logic [15:0]   mem1 [0:4095];
   logic [15:0]   mem3 [0:4095];
   logic [4095:0] wr1, wr3;

   always @(posedge clk) begin
      if (clr_mem) begin
         wr1 <= '0;
         wr3 <= '0;
      end else begin
         if (b1.ram_wren) begin
            mem1[b1.ram_addr] <= b1.ram_wdata;
            wr1[b1.ram_addr]  <= 1'b1;
         end
         if (b3.ram_wren) begin
            mem3[b3.ram_addr] <= b3.ram_wdata;
            wr3[b3.ram_addr]  <= 1'b1;
         end
      end
   end

   assign b1.ram_q = wr1[b1.ram_addr] ? mem1[b1.ram_addr] : ram_init(b1.ram_addr);
   assign b3.ram_q = wr3[b3.ram_addr] ? mem3[b3.ram_addr] : ram_init(b3.ram_addr);

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   typedef struct packed {
      logic        fr;
      logic [11:0] pc;
      logic        mr;
      logic        we;
      logic [11:0] ma;
      logic [15:0] md;
      logic        e_rdy;
      logic        e_stall;
      logic        e_wren;
      logic        e_iv;
      logic        e_lv;
      logic [11:0] e_addr;
      logic [15:0] e_wd;
      logic [15:0] e_rd;
   } vec_t;

   vec_t tbl [0:13];

   logic [15:0] refm [0:4095];
   int          q_kind [$];
   logic [15:0] q_data [$];

   initial begin
      int          pend;
      logic [11:0] r_addr;
      logic [15:0] r_data;
      logic        prev_wren;
      int          nw;

      b1.fetch_req = 1'b0; b1.pc = '0; b1.mem_req = 1'b0; b1.mem_we = 1'b0;
      b1.mem_addr  = '0;   b1.mem_wdata = '0;
      b3.fetch_req = 1'b0; b3.pc = '0; b3.mem_req = 1'b0; b3.mem_we = 1'b0;
      b3.mem_addr  = '0;   b3.mem_wdata = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk("rst1.ready", b1.ready, 1);      chk("rst1.stall", b1.stall, 0);
      chk("rst1.iv", b1.instr_valid, 0);   chk("rst1.lv", b1.load_valid, 0);
      chk("rst1.rdata", b1.rdata_out, 0);  chk("rst1.addr", b1.ram_addr, 0);
      chk("rst1.wren", b1.ram_wren, 0);    chk("rst1.wdata", b1.ram_wdata, 0);
      chk("rst3.ready", b3.ready, 1);      chk("rst3.iv", b3.instr_valid, 0);
      chk("rst3.lv", b3.load_valid, 0);    chk("rst3.wren", b3.ram_wren, 0);
      chk("rst3.addr", b3.ram_addr, 0);
      clr_mem = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

`ifndef STORE_BUF_EN
      //            fr    pc       mr    we    ma       md          rdy   stl   wren  iv    lv    addr     wd          rd
      tbl[0]  = '{1'b0, 12'h010, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b0, 12'h010, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 16'h0000, 16'h0000};
      tbl[3]  = '{1'b0, 12'h020, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h010, 16'h0000, 16'hA5A5};
      tbl[4]  = '{1'b0, 12'h020, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 16'h0000, 16'hA5A5};
      tbl[5]  = '{1'b0, 12'h020, 1'b1, 1'b1, 12'h123, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 16'h0000, 16'hA5A5};
      tbl[6]  = '{1'b0, 12'h020, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 16'hBEEF, 16'hA5A5};
      tbl[7]  = '{1'b0, 12'h020, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 16'hBEEF, 16'hA5A5};
      tbl[8]  = '{1'b0, 12'h030, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 16'hBEEF, 16'hA5A5};
      tbl[9]  = '{1'b1, 12'h030, 1'b1, 1'b0, 12'h123, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h030, 16'hBEEF, 16'hA5A5};
      tbl[10] = '{1'b1, 12'h030, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123, 16'hBEEF, 16'hA5A5};
      tbl[11] = '{1'b1, 12'h030, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 16'hBEEF, 16'hBEEF};
      tbl[12] = '{1'b0, 12'h030, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h030, 16'hBEEF, 16'hBEEF};
      tbl[13] = '{1'b0, 12'h030, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h030, 16'hBEEF, 16'h5A5A};

      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         b1.fetch_req = tbl[k].fr; b1.pc = tbl[k].pc;
         b1.mem_req   = tbl[k].mr; b1.mem_we = tbl[k].we;
         b1.mem_addr  = tbl[k].ma; b1.mem_wdata = tbl[k].md;
         #1;
         chk($sformatf("v%0d.ready", k), b1.ready,       tbl[k].e_rdy);
         chk($sformatf("v%0d.stall", k), b1.stall,       tbl[k].e_stall);
         chk($sformatf("v%0d.wren", k),  b1.ram_wren,    tbl[k].e_wren);
         chk($sformatf("v%0d.iv", k),    b1.instr_valid, tbl[k].e_iv);
         chk($sformatf("v%0d.lv", k),    b1.load_valid,  tbl[k].e_lv);
         chk($sformatf("v%0d.addr", k),  b1.ram_addr,    tbl[k].e_addr);
         chk($sformatf("v%0d.wdata", k), b1.ram_wdata,   tbl[k].e_wd);
         chk($sformatf("v%0d.rdata", k), b1.rdata_out,   tbl[k].e_rd);
      end
`else
      // Posted store then immediate load of the same word (forwarded).
      @(negedge clk);
      b1.mem_req = 1'b1; b1.mem_we = 1'b1; b1.mem_addr = 12'h040; b1.mem_wdata = 16'h1234;
      #1; chk("sb.ready_st", b1.ready, 1);
      @(negedge clk);
      b1.mem_we = 1'b0;
      #1; chk("sb.ready_ld", b1.ready, 1); chk("sb.wren_ld", b1.ram_wren, 0);
      @(negedge clk);
      b1.mem_req = 1'b0;
      #1; chk("sb.lv_early", b1.load_valid, 0);
      @(negedge clk);
      #1; chk("sb.lv", b1.load_valid, 1); chk("sb.fwd", b1.rdata_out, 16'h1234);
      nw = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (b1.ram_wren) begin
            nw++;
            chk("sb.wr_addr", b1.ram_addr, 12'h040);
            chk("sb.wr_data", b1.ram_wdata, 16'h1234);
         end
      end
      chk("sb.nwrites", nw, 1);
      @(negedge clk);
      b1.mem_req = 1'b1; b1.mem_we = 1'b0; b1.mem_addr = 12'h040;
      @(negedge clk);
      b1.mem_req = 1'b0;
      @(negedge clk);
      #1; chk("sb.lv2", b1.load_valid, 1); chk("sb.ram_rd", b1.rdata_out, 16'h1234);
`endif

      // RD_LAT=3: load and fetch together, load wins, fetch held until taken.
      b3.pc = 12'h050; b3.mem_addr = 12'h200; b3.mem_we = 1'b0;
      for (int c = 0; c <= 9; c++) begin
         @(negedge clk);
         b3.fetch_req = (c <= 4);
         b3.mem_req   = (c == 0);
         #1;
         chk($sformatf("pr%0d.ready", c), b3.ready, (c == 0 || c == 4 || c >= 8));
         chk($sformatf("pr%0d.stall", c), b3.stall, (c >= 1 && c <= 3));
         chk($sformatf("pr%0d.lv", c),    b3.load_valid, (c == 4));
         chk($sformatf("pr%0d.iv", c),    b3.instr_valid, (c == 8));
         chk($sformatf("pr%0d.wren", c),  b3.ram_wren, 0);
         if (c == 4) chk("pr.ld_data", b3.rdata_out, 16'h1111);
         if (c == 8) chk("pr.if_data", b3.rdata_out, 16'h2222);
      end

      // Reset while a load is in flight.
      @(negedge clk);
      b3.mem_req = 1'b1; b3.mem_addr = 12'h200;
      #1; chk("mr.ready0", b3.ready, 1);
      @(negedge clk);
      b3.mem_req = 1'b0;
      #1; chk("mr.ready1", b3.ready, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr.lv", b3.load_valid, 0); chk("mr.ready", b3.ready, 1);
      chk("mr.addr", b3.ram_addr, 0); chk("mr.rdata", b3.rdata_out, 0);
      chk("mr.wren", b3.ram_wren, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         chk($sformatf("mr%0d.lv", c),   b3.load_valid, 0);
         chk($sformatf("mr%0d.iv", c),   b3.instr_valid, 0);
         chk($sformatf("mr%0d.wren", c), b3.ram_wren, 0);
      end

      // Random request stream on the RD_LAT=1 instance.
      for (int i = 0; i < 4096; i++)
         refm[i] = wr1[i] ? mem1[i] : ram_init(12'(i));
      pend = 0; prev_wren = 1'b0; r_addr = '0; r_data = '0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (pend == 0 && cyc < 560) begin
            pend   = $urandom_range(3, 0);
            r_addr = 12'h100 + 12'($urandom_range(7, 0));
            r_data = 16'($urandom);
         end
         b1.fetch_req = (pend == 1); b1.pc = r_addr;
         b1.mem_req   = (pend >= 2); b1.mem_we = (pend == 3);
         b1.mem_addr  = r_addr;      b1.mem_wdata = r_data;
         #1;
         if (b1.instr_valid || b1.load_valid) begin
            chk("rnd.both", b1.instr_valid & b1.load_valid, 0);
            chk("rnd.queued", q_kind.size() > 0, 1);
            if (q_kind.size() > 0) begin
               chk("rnd.kind", b1.load_valid ? 2 : 1, q_kind.pop_front());
               chk("rnd.data", b1.rdata_out, q_data.pop_front());
            end
         end
         if (b1.ram_wren) chk("rnd.wr_1cyc", prev_wren, 0);
         prev_wren = b1.ram_wren;
         if (pend != 0 && b1.ready) begin
            if (pend == 3) begin
               refm[r_addr] = r_data;
            end else begin
               q_kind.push_back(pend == 1 ? 1 : 2);
               q_data.push_back(refm[r_addr]);
            end
            pend = 0;
         end
      end
      chk("rnd.pending", q_kind.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
